// File: rtl/lab1_imul_int_mul_nbit_if.sv
// Request/response stream bundle for the iterative multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface lab1_imul_int_mul_nbit_if #(
  parameter int p_nbits = 32
);
  logic                   istream_val;
  logic                   istream_rdy;
  logic [2*p_nbits-1:0]   istream_msg;
  logic                   ostream_val;
  logic                   ostream_rdy;
  logic [p_nbits-1:0]     ostream_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/lab1_imul_int_mul_nbit.sv
// Iterative shift-and-add multiplier, one operand bit per cycle, result mod 2^p_nbits.
// Define LAB1_IMUL_INT_MUL_NBIT_EARLY_EXIT_EN to leave CALC once the remaining b bits are zero.
module lab1_imul_int_mul_nbit #(
  parameter int p_nbits = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  lab1_imul_int_mul_nbit_if.slave  io
);
  localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [p_nbits-1:0] a_q, a_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] result_q, result_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef LAB1_IMUL_INT_MUL_NBIT_EARLY_EXIT_EN
  assign last_step = (cnt_q == CW'(p_nbits - 1)) || ((b_q >> 1) == '0);
`else
  assign last_step = (cnt_q == CW'(p_nbits - 1));
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.istream_val) state_d = CALC;
      CALC:    if (last_step)      state_d = DONE;
      DONE:    if (io.ostream_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: if (io.istream_val) begin
        a_d      = io.istream_msg[2*p_nbits-1:p_nbits];
        b_d      = io.istream_msg[p_nbits-1:0];
        result_d = '0;
        cnt_d    = '0;
      end
      CALC: begin
        if (b_q[0]) result_d = result_q + a_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
        // hold the counter on the final step so it never wraps
        if (!last_step) cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    io.istream_rdy = (state_q == IDLE);
    io.ostream_val = (state_q == DONE);
    io.ostream_msg = result_q;
  end
endmodule

// File: tb/tb_lab1_imul_int_mul_nbit.sv
// Directed bench for the iterative multiplier: 32-bit and 8-bit instances.
// Expected latencies follow LAB1_IMUL_INT_MUL_NBIT_EARLY_EXIT_EN when it is defined.
module tb_lab1_imul_int_mul_nbit;
  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  lab1_imul_int_mul_nbit_if #(.p_nbits(32)) m32 ();
  lab1_imul_int_mul_nbit_if #(.p_nbits(8))  m8  ();

  lab1_imul_int_mul_nbit #(.p_nbits(32)) u_dut32 (.clk(clk), .reset(reset), .io(m32));
  lab1_imul_int_mul_nbit #(.p_nbits(8))  u_dut8  (.clk(clk), .reset(reset), .io(m8));

`ifdef LAB1_IMUL_INT_MUL_NBIT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on the 32-bit instance; hold = cycles of ostream_rdy=0 in DONE.
  task automatic mul32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input int lat, input int hold, input string tag);
    int k;
    bit seen;
    m32.istream_val = 1'b1;
    m32.istream_msg = {a, b};
    m32.ostream_rdy = (hold == 0);
    chk({tag, "/in_rdy"}, 64'(m32.istream_rdy), 64'd1);
    step();
    m32.istream_val = 1'b0;
    chk({tag, "/busy"}, 64'({m32.istream_rdy, m32.ostream_val}), 64'd0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      if (m32.ostream_val) seen = 1'b1;
      else begin
        m32.istream_val = 1'($urandom);
        m32.istream_msg = {$urandom, $urandom};
        step();
        k++;
      end
    end
    m32.istream_val = 1'b0;
    chk({tag, "/timeout"}, 64'(seen), 64'd1);
    if (lat >= 0) chk({tag, "/lat"}, 64'(k), 64'(lat));
    chk({tag, "/msg"}, 64'(m32.ostream_msg), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "/hold"}, 64'({m32.ostream_val, m32.istream_rdy, m32.ostream_msg}),
          64'({1'b1, 1'b0, exp}));
      step();
    end
    m32.ostream_rdy = 1'b1;
    if (hold > 0) chk({tag, "/still_done"}, 64'(m32.ostream_val), 64'd1);
    step();
    chk({tag, "/idle"}, 64'({m32.istream_rdy, m32.ostream_val}), 64'b10);
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                      input int lat, input string tag);
    int k;
    m8.istream_val = 1'b1;
    m8.istream_msg = {a, b};
    m8.ostream_rdy = 1'b1;
    step();
    m8.istream_val = 1'b0;
    k = 0;
    while (!m8.ostream_val && k < 50) begin
      step();
      k++;
    end
    chk({tag, "/lat"}, 64'(k), 64'(lat));
    chk({tag, "/msg"}, 64'(m8.ostream_msg), 64'(exp));
    step();
    chk({tag, "/idle"}, 64'({m8.istream_rdy, m8.ostream_val}), 64'b10);
  endtask

  initial begin
    logic [31:0] a, b, na, nb, p;
    int k, rcyc;
    logic bad;

    // reset with a pending request: it must not be taken
    reset = 1'b1;
    m32.istream_val = 1'b1;
    m32.istream_msg = {32'd2, 32'd3};
    m32.ostream_rdy = 1'b1;
    m8.istream_val  = 1'b1;
    m8.istream_msg  = 16'h0203;
    m8.ostream_rdy  = 1'b1;
    step();
    step();
    reset = 1'b0;
    m32.istream_val = 1'b0;
    m8.istream_val  = 1'b0;
    chk("rst/out32", 64'({m32.istream_rdy, m32.ostream_val, m32.ostream_msg}), 64'({1'b1, 1'b0, 32'd0}));
    step();
    chk("rst/after32", 64'({m32.istream_rdy, m32.ostream_val, m32.ostream_msg}), 64'({1'b1, 1'b0, 32'd0}));
    chk("rst/after8", 64'({m8.istream_rdy, m8.ostream_val, m8.ostream_msg}), 64'({1'b1, 1'b0, 8'd0}));

    mul32(32'd2,          32'd3,          32'h0000_0006, EE ? 2 : 32, 0, "2x3");
    mul32(32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA, EE ? 2 : 32, 0, "neg2x3");
    mul32(32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 32,          0, "msb");
    mul32(32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB, EE ? 3 : 32, 0, "neg3x7");
    mul32(32'h0000_1234,  32'h0000_0010,  32'h0001_2340, EE ? 5 : 32, 5, "bp");

    mul8(8'hFF, 8'hFF, 8'h01, 8,          "n8/ffxff");
    mul8(8'h12, 8'h00, 8'h00, EE ? 1 : 8, "n8/bzero");

    // abort an operation mid-flight with a reset pulse
    rcyc = EE ? 3 : 10;
    m32.istream_val = 1'b1;
    m32.istream_msg = {32'd7, 32'd9};
    m32.ostream_rdy = 1'b1;
    step();
    m32.istream_val = 1'b0;
    bad = 1'b0;
    for (int i = 1; i < rcyc; i++) begin
      bad |= m32.ostream_val;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort/reset", 64'({m32.istream_rdy, m32.ostream_val, m32.ostream_msg}), 64'({1'b1, 1'b0, 32'd0}));
    step();
    chk("abort/rdy", 64'(m32.istream_rdy), 64'd1);
    for (int i = 0; i < 40; i++) begin
      bad |= m32.ostream_val;
      step();
    end
    chk("abort/no_result", 64'(bad), 64'd0);
    mul32(32'd5, 32'd6, 32'h0000_001E, EE ? 3 : 32, 0, "5x6");

    // back-to-back with istream_val held high
    m32.ostream_rdy = 1'b1;
    m32.istream_val = 1'b1;
    a = $urandom;
    b = $urandom;
    m32.istream_msg = {a, b};
    step();
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (!m32.ostream_val && k < 40) begin
        step();
        k++;
      end
      p = a * b;
      chk($sformatf("b2b%0d/msg", i), 64'(m32.ostream_msg), 64'(p));
      na = $urandom;
      nb = $urandom;
      m32.istream_msg = {na, nb};
      step();
      chk($sformatf("b2b%0d/idle", i), 64'({m32.istream_rdy, m32.ostream_val}), 64'b10);
      step();
      chk($sformatf("b2b%0d/acc", i), 64'(m32.istream_rdy), 64'd0);
      a = na;
      b = nb;
    end
    m32.istream_val = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
